// File: rtl/rtype_pkg.sv
// -----------------------------------------------------------------------------
// rtype_pkg
// Shared definitions for the RV32 R-type ADD/SUB sequencer and its decoder:
//   - major opcode / funct3 / funct7 encodings accepted by the integer path
//   - sequencer state enumeration (3-bit encoding)
//   - instruction field bit positions, so every consumer slices identically
// -----------------------------------------------------------------------------
package rtype_pkg;

  // Encodings of the only instructions this path executes.
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

  // R-type field positions inside the 32-bit instruction word.
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  // Sequencer states. One instruction is in flight at a time; HALT is only
  // left through an explicit start pulse.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/rtype_field_dec.sv
// -----------------------------------------------------------------------------
// rtype_field_dec
// Purely combinational R-type field decoder. Kept separate from the sequencer
// so later execute stages can reuse the same legality rule.
//
// Ports:
//   ir      in   32  instruction word
//   rs1     out  5   source register 1 (ir[19:15])
//   rs2     out  5   source register 2 (ir[24:20])
//   rd      out  5   destination register (ir[11:7])
//   legal   out  1   encoding is ADD or SUB (OP major opcode, funct3=000)
//   is_sub  out  1   funct7 selects subtract
// -----------------------------------------------------------------------------
module rtype_field_dec (
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        legal,
  output logic        is_sub
);
  import rtype_pkg::*;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;

  // Slice the register fields and classify the encoding.
  always_comb begin
    opcode_s = ir[OPC_MSB:OPC_LSB];
    funct3_s = ir[F3_MSB:F3_LSB];
    funct7_s = ir[F7_MSB:F7_LSB];
    rs1      = ir[RS1_MSB:RS1_LSB];
    rs2      = ir[RS2_MSB:RS2_LSB];
    rd       = ir[RD_MSB:RD_LSB];

    if ((opcode_s == OPC_OP) && (funct3_s == F3_ADDSUB) &&
        ((funct7_s == F7_ADD) || (funct7_s == F7_SUB))) begin
      legal = 1'b1;
    end else begin
      legal = 1'b0;
    end

    // Only meaningful together with legal; the sequencer ignores it otherwise.
    if (funct7_s == F7_SUB) begin
      is_sub = 1'b1;
    end else begin
      is_sub = 1'b0;
    end
  end

endmodule

// File: rtl/rtype_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rtype_seq_ctrl
// Multi-cycle sequencer for the RV32 R-type ADD/SUB integer path. Fetches one
// instruction at a time over a req/ack port, decodes it, then drives the
// register-file addresses, ALU op select and write enable. No pipelining:
// FETCH (>=1 cycle) -> DECODE -> EXEC -> WB -> FETCH ...
//
// Parameters:
//   RESET_PC     PC loaded by an accepted start
//   ACK_TIMEOUT  FETCH cycles allowed without imem_ack before a timeout halt (>=1)
//   PC_STEP      byte increment per retired instruction
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset, overrides everything
//   start        in   1   pulse; honoured only in IDLE or HALT
//   imem_req     out  1   fetch request (high for the whole FETCH state)
//   imem_addr    out  32  fetch address, stable while imem_req=1
//   imem_ack     in   1   instruction data valid (ignored outside FETCH)
//   imem_rdata   in   32  instruction word
//   rf_rs1/rs2   out  5   register-file read addresses (held between instrs)
//   rf_rd        out  5   register-file write address (held between instrs)
//   rf_we        out  1   write-enable pulse in WB, suppressed for x0
//   alu_en       out  1   ALU operand-latch pulse in EXEC
//   alu_sub      out  1   0=add, 1=sub
//   busy         out  1   FETCH/DECODE/EXEC/WB
//   halted       out  1   HALT
//   err_illegal  out  1   sticky, non-ADD/SUB seen (cleared by start)
//   err_timeout  out  1   sticky, fetch timed out (cleared by start)
//   retired_cnt  out  32  only with RTYPE_SEQ_RETIRE_CNT_EN: WB count, wraps
//
// Optional feature macro: RTYPE_SEQ_RETIRE_CNT_EN adds the retired_cnt port.
// All outputs are registered; they are computed from the next state so that
// each output is valid during the state it belongs to.
// -----------------------------------------------------------------------------
module rtype_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [4:0]  rf_rd,
  output logic        rf_we,
  output logic        alu_en,
  output logic        alu_sub,
  output logic        busy,
  output logic        halted,
  output logic        err_illegal,
  output logic        err_timeout
`ifdef RTYPE_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);
  import rtype_pkg::*;

  // Wide enough to hold ACK_TIMEOUT-1, the last value before expiry.
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  // Architectural state
  state_e        state_r;
  logic [31:0]   pc_r;
  logic [31:0]   ir_r;
  logic [TW-1:0] tmo_cnt_r;

  // Registered outputs
  logic          imem_req_r;
  logic [31:0]   imem_addr_r;
  logic [4:0]    rs1_r;
  logic [4:0]    rs2_r;
  logic [4:0]    rd_r;
  logic          rf_we_r;
  logic          alu_en_r;
  logic          alu_sub_r;
  logic          busy_r;
  logic          halted_r;
  logic          err_illegal_r;
  logic          err_timeout_r;

  // Next-state values
  state_e        state_nx_s;
  logic [31:0]   pc_nx_s;
  logic [31:0]   ir_nx_s;
  logic [TW-1:0] tmo_cnt_nx_s;
  logic          err_illegal_nx_s;
  logic          err_timeout_nx_s;
  logic          latch_fields_s;
  logic          last_wait_s;

  // Decoded view of the current IR
  logic [4:0]    dec_rs1_s;
  logic [4:0]    dec_rs2_s;
  logic [4:0]    dec_rd_s;
  logic          dec_legal_s;
  logic          dec_is_sub_s;

  rtype_field_dec u_dec (
    .ir     (ir_r),
    .rs1    (dec_rs1_s),
    .rs2    (dec_rs2_s),
    .rd     (dec_rd_s),
    .legal  (dec_legal_s),
    .is_sub (dec_is_sub_s)
  );

  // The counter holds the number of ack-less FETCH cycles already spent, so
  // the current cycle is the ACK_TIMEOUT-th one when it equals ACK_TIMEOUT-1.
  assign last_wait_s = (tmo_cnt_r == TW'(ACK_TIMEOUT - 1));

  // Next-state, PC, IR, timeout counter and sticky-flag logic.
  always_comb begin
    state_nx_s       = state_r;
    pc_nx_s          = pc_r;
    ir_nx_s          = ir_r;
    tmo_cnt_nx_s     = tmo_cnt_r;
    err_illegal_nx_s = err_illegal_r;
    err_timeout_nx_s = err_timeout_r;
    latch_fields_s   = 1'b0;

    case (state_r)
      IDLE, HALT: begin
        if (start) begin
          state_nx_s       = FETCH;
          pc_nx_s          = RESET_PC;
          tmo_cnt_nx_s     = '0;
          err_illegal_nx_s = 1'b0;
          err_timeout_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end

      FETCH: begin
        // An ack wins even on the very last allowed cycle.
        if (imem_ack) begin
          ir_nx_s      = imem_rdata;
          tmo_cnt_nx_s = '0;
          state_nx_s   = DECODE;
        end else if (last_wait_s) begin
          tmo_cnt_nx_s     = '0;
          err_timeout_nx_s = 1'b1;
          state_nx_s       = HALT;
        end else begin
          tmo_cnt_nx_s = tmo_cnt_r + TW'(1);
        end
      end

      DECODE: begin
        if (dec_legal_s) begin
          latch_fields_s = 1'b1;
          state_nx_s     = EXEC;
        end else begin
          err_illegal_nx_s = 1'b1;
          state_nx_s       = HALT;
        end
      end

      EXEC: begin
        state_nx_s = WB;
      end

      WB: begin
        // Natural 32-bit wrap: 0xFFFF_FFFC + 4 becomes 0 with no error.
        pc_nx_s    = pc_r + PC_STEP;
        state_nx_s = FETCH;
      end

      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered-output update; rst has absolute priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      ir_r          <= 32'h0000_0000;
      tmo_cnt_r     <= '0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= 32'h0000_0000;
      rs1_r         <= 5'd0;
      rs2_r         <= 5'd0;
      rd_r          <= 5'd0;
      rf_we_r       <= 1'b0;
      alu_en_r      <= 1'b0;
      alu_sub_r     <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      err_illegal_r <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      pc_r          <= pc_nx_s;
      ir_r          <= ir_nx_s;
      tmo_cnt_r     <= tmo_cnt_nx_s;
      err_illegal_r <= err_illegal_nx_s;
      err_timeout_r <= err_timeout_nx_s;

      imem_req_r <= (state_nx_s == FETCH);
      alu_en_r   <= (state_nx_s == EXEC);
      // rd_r was latched on the DECODE->EXEC edge, so it is valid here.
      rf_we_r    <= (state_nx_s == WB) && (rd_r != 5'd0);
      busy_r     <= (state_nx_s == FETCH) || (state_nx_s == DECODE) ||
                    (state_nx_s == EXEC)  || (state_nx_s == WB);
      halted_r   <= (state_nx_s == HALT);

      // Address only moves on entry to FETCH, keeping it stable under req.
      if (state_nx_s == FETCH) begin
        imem_addr_r <= pc_nx_s;
      end

      // Register addresses and op select hold their last decoded values.
      if (latch_fields_s) begin
        rs1_r     <= dec_rs1_s;
        rs2_r     <= dec_rs2_s;
        rd_r      <= dec_rd_s;
        alu_sub_r <= dec_is_sub_s;
      end
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign rf_rs1      = rs1_r;
  assign rf_rs2      = rs2_r;
  assign rf_rd       = rd_r;
  assign rf_we       = rf_we_r;
  assign alu_en      = alu_en_r;
  assign alu_sub     = alu_sub_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign err_illegal = err_illegal_r;
  assign err_timeout = err_timeout_r;

`ifdef RTYPE_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt_r;
  logic        cnt_clr_s;
  logic        cnt_inc_s;

  // Only an accepted start clears the count; WB is the sole retire point, so
  // illegal and timed-out instructions never reach it.
  assign cnt_clr_s = start && ((state_r == IDLE) || (state_r == HALT));
  assign cnt_inc_s = (state_r == WB);

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_r <= 32'd0;
    end else if (cnt_clr_s) begin
      retired_cnt_r <= 32'd0;
    end else if (cnt_inc_s) begin
      retired_cnt_r <= retired_cnt_r + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_r;
`endif

endmodule
